// File: rtl/wb_ctrl.sv
// wb_ctrl: write-back controller for the 8x8 register file write port.
// Merges unstallable ALU results with buffered load results, keeps a
// per-register pending-write scoreboard and requests a stall when loads
// are starved by back-to-back ALU writes.
module wb_ctrl #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       issue_valid,
    input  logic [2:0] issue_rd,
    input  logic       alu_valid,
    input  logic [2:0] alu_rd,
    input  logic [7:0] alu_data,
    input  logic       mem_valid,
    output logic       mem_ready,
    input  logic [2:0] mem_rd,
    input  logic [7:0] mem_data,
    output logic       we3,
    output logic [2:0] wa3,
    output logic [7:0] wd3,
    output logic [7:0] busy,
    output logic       stall_req
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] STV_ONE   = CW'(1);
    localparam logic [CW-1:0] STV_LIMIT = CW'(STARVE_LIMIT);

    // Load-result FIFO storage; the payload is never reset, only the pointers.
    logic [2:0]    fifo_rd   [DEPTH];
    logic [7:0]    fifo_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    logic          sel_vld_p0;
    logic [2:0]    sel_rd_p0;
    logic [7:0]    sel_data_p0;

    logic [7:0]    busy_next;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_next;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign mem_ready = !full;
    assign push      = mem_valid && !full;
    assign pop       = !alu_valid && !empty;

    // Arbitration: the ALU always wins, otherwise the FIFO head is taken.
    always_comb begin
        sel_vld_p0  = 1'b0;
        sel_rd_p0   = 3'd0;
        sel_data_p0 = 8'd0;
        if (alu_valid) begin
            sel_vld_p0  = 1'b1;
            sel_rd_p0   = alu_rd;
            sel_data_p0 = alu_data;
        end else if (!empty) begin
            sel_vld_p0  = 1'b1;
            sel_rd_p0   = fifo_rd[rd_ptr];
            sel_data_p0 = fifo_data[rd_ptr];
        end
    end

    // Scoreboard next state: clear on selection, a same-cycle issue wins.
    always_comb begin
        busy_next = busy;
        if (sel_vld_p0) begin
            busy_next[sel_rd_p0] = 1'b0;
        end
        if (issue_valid) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Starvation counter next state: saturates while a non-empty FIFO loses.
    always_comb begin
        starve_next = starve_cnt;
        if (pop || empty) begin
            starve_next = '0;
        end else if (alu_valid && (starve_cnt != STV_LIMIT)) begin
            starve_next = starve_cnt + STV_ONE;
        end
    end

    // FIFO payload write in acceptance order.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= mem_rd;
            fifo_data[wr_ptr] <= mem_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // ---- stage boundary: selection -> register-file write port ----
    // Register the selected result; register 0 writes are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we3 <= 1'b0;
            wa3 <= 3'd0;
            wd3 <= 8'd0;
        end else begin
            we3 <= sel_vld_p0 && (sel_rd_p0 != 3'd0);
            if (sel_vld_p0 && (sel_rd_p0 != 3'd0)) begin
                wa3 <= sel_rd_p0;
                wd3 <= sel_data_p0;
            end
        end
    end

    // Scoreboard, starvation counter and registered stall request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= 8'd0;
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            busy       <= busy_next;
            starve_cnt <= starve_next;
            stall_req  <= (starve_next == STV_LIMIT);
        end
    end

endmodule

// File: tb/tb_wb_ctrl.sv
// tb_wb_ctrl: directed scenarios plus randomized traffic for wb_ctrl,
// checked every cycle against a queue-based behavioural model.
module tb_wb_ctrl;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       issue_valid;
    logic [2:0] issue_rd;
    logic       alu_valid;
    logic [2:0] alu_rd;
    logic [7:0] alu_data;
    logic       mem_valid;
    logic       mem_ready;
    logic [2:0] mem_rd;
    logic [7:0] mem_data;
    logic       we3;
    logic [2:0] wa3;
    logic [7:0] wd3;
    logic [7:0] busy;
    logic       stall_req;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [10:0] mq[$];
    logic [7:0]  m_busy;
    int          m_cnt;
    logic        e_we;
    logic [2:0]  e_wa;
    logic [7:0]  e_wd;
    logic        e_stall;
    logic        last_accept;

    wb_ctrl #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_data(mem_data),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .busy(busy), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy  = 8'd0;
        m_cnt   = 0;
        e_we    = 1'b0;
        e_wa    = 3'd0;
        e_wd    = 8'd0;
        e_stall = 1'b0;
    endtask

    // One clock: check mem_ready, advance the model on the edge, check outputs.
    task automatic cycle();
        int          pre_size;
        logic        sel;
        logic        popped;
        logic [2:0]  srd;
        logic [7:0]  sd;
        logic [10:0] ent;
        pre_size = mq.size();
        chk("mem_ready", mem_ready, pre_size < DEPTH);
        last_accept = mem_valid && (pre_size < DEPTH);
        @(posedge clk);
        sel = 1'b0; popped = 1'b0; srd = 3'd0; sd = 8'd0;
        if (alu_valid) begin
            sel = 1'b1; srd = alu_rd; sd = alu_data;
        end else if (pre_size > 0) begin
            ent = mq.pop_front();
            sel = 1'b1; popped = 1'b1; srd = ent[10:8]; sd = ent[7:0];
        end
        if (last_accept) mq.push_back({mem_rd, mem_data});
        e_we = sel && (srd != 3'd0);
        if (e_we) begin
            e_wa = srd; e_wd = sd;
        end
        if (sel) m_busy[srd] = 1'b0;
        if (issue_valid && issue_rd != 3'd0) m_busy[issue_rd] = 1'b1;
        if (popped || pre_size == 0) m_cnt = 0;
        else if (alu_valid) m_cnt = (m_cnt + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_cnt + 1;
        e_stall = (m_cnt == STARVE_LIMIT);
        #1;
        chk("we3", we3, e_we);
        if (e_we) begin
            chk("wa3", wa3, e_wa);
            chk("wd3", wd3, e_wd);
        end
        chk("busy", busy, m_busy);
        chk("stall_req", stall_req, e_stall);
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_rd = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        chk("rst_we3", we3, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_wa3", wa3, 0);
        chk("rst_wd3", wd3, 0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        #1 chk("ready_after_rst", mem_ready, 1);

        // Single ALU write
        issue_valid = 1; issue_rd = 3;
        cycle();
        chk("busy3_set", busy[3], 1);
        issue_valid = 0;
        alu_valid = 1; alu_rd = 3; alu_data = 8'hA5;
        cycle();
        chk("alu_we", we3, 1); chk("alu_wa", wa3, 3); chk("alu_wd", wd3, 8'hA5);
        chk("busy3_clr", busy[3], 0);
        idle_inputs();
        cycle();

        // Priority and buffering
        alu_valid = 1; alu_rd = 2; alu_data = 8'h22;
        mem_valid = 1; mem_rd = 5; mem_data = 8'h11;
        cycle();
        chk("prio_alu_wa", wa3, 2); chk("prio_alu_wd", wd3, 8'h22);
        idle_inputs();
        cycle();
        chk("prio_ld_we", we3, 1); chk("prio_ld_wa", wa3, 5); chk("prio_ld_wd", wd3, 8'h11);
        alu_valid = 1; alu_rd = 1; alu_data = 8'h01;
        mem_valid = 1; mem_rd = 6; mem_data = 8'h33;
        cycle();
        mem_rd = 7; mem_data = 8'h44; alu_data = 8'h02;
        cycle();
        chk("fifo_full", mem_ready, 0);
        idle_inputs();
        repeat (3) cycle();

        // Register 0
        alu_valid = 1; alu_rd = 0; alu_data = 8'hFF;
        cycle();
        chk("r0_alu_we", we3, 0);
        idle_inputs();
        mem_valid = 1; mem_rd = 0; mem_data = 8'h77;
        cycle();
        idle_inputs();
        cycle();
        chk("r0_ld_we", we3, 0);
        chk("r0_busy0", busy[0], 0);
        chk("r0_drained", mem_ready, 1);
        cycle();

        // Starvation
        alu_valid = 1; alu_rd = 2; alu_data = 8'h10;
        mem_valid = 1; mem_rd = 1; mem_data = 8'h5A;
        cycle();
        mem_valid = 0;
        for (int i = 1; i <= 6; i++) begin
            alu_data = 8'(8'h10 + i);
            cycle();
            chk("starve_stall", stall_req, (i >= STARVE_LIMIT));
        end
        idle_inputs();
        cycle();
        chk("starve_ld_wa", wa3, 1); chk("starve_ld_wd", wd3, 8'h5A);
        chk("starve_release", stall_req, 0);

        // Scoreboard collision
        issue_valid = 1; issue_rd = 4;
        cycle();
        alu_valid = 1; alu_rd = 4; alu_data = 8'h40;
        cycle();
        chk("coll_busy4_kept", busy[4], 1);
        issue_valid = 0; alu_data = 8'h41;
        cycle();
        chk("coll_busy4_clr", busy[4], 0);
        idle_inputs();
        cycle();

        // Reset mid-stream with two loads buffered and busy=0C
        issue_valid = 1; issue_rd = 2;
        cycle();
        issue_rd = 3;
        alu_valid = 1; alu_rd = 6; alu_data = 8'h66;
        mem_valid = 1; mem_rd = 1; mem_data = 8'hC1;
        cycle();
        issue_valid = 0;
        mem_rd = 5; mem_data = 8'hC5;
        cycle();
        chk("pre_rst_busy", busy, 8'h0C);
        chk("pre_rst_full", mem_ready, 0);
        idle_inputs();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_we3", we3, 0); chk("mid_rst_wa3", wa3, 0); chk("mid_rst_wd3", wd3, 0);
        chk("mid_rst_busy", busy, 0); chk("mid_rst_stall", stall_req, 0);
        @(posedge clk); #1;
        chk("mid_rst_hold_we3", we3, 0);
        reset_n = 1'b1;
        #1 chk("mid_rst_ready", mem_ready, 1);
        repeat (3) cycle();

        // Randomized traffic respecting the load hold rule
        for (int i = 0; i < 400; i++) begin
            if (!(mem_valid && !last_accept)) begin
                mem_valid = ($urandom_range(0, 2) != 0);
                mem_rd    = 3'($urandom_range(0, 7));
                mem_data  = 8'($urandom);
            end
            issue_valid = $urandom_range(0, 1);
            issue_rd    = 3'($urandom_range(0, 7));
            alu_valid   = stall_req ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
            alu_rd      = 3'($urandom_range(0, 7));
            alu_data    = 8'($urandom);
            cycle();
        end
        idle_inputs();
        repeat (4) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
